// File: rtl/dmem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | dmem_stage - multi-cycle Y86-64 data-memory stage; DMEM_ALIGN_CHECK_EN adds     |
// | misalignment faults.  Rev 1.0                                                   |
// +--------------------------------------------------------------------------------+
module dmem_stage #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M_valid,
  input  logic [2:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  output logic              m_valid,
  output logic [2:0]        m_stat,
  output logic [3:0]        m_icode,
  output logic [DATA_W-1:0] m_valE,
  output logic [DATA_W-1:0] m_valM,
  output logic [3:0]        m_dstE,
  output logic [3:0]        m_dstM,
  output logic              m_stall
);

  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SADR    = 3'd2;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam int         AW      = $clog2(DEPTH);
  localparam int         CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;

  // Contents survive rst; only power-up initialisation clears them.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  logic              w_is_wr, w_is_rd, w_fault, w_access;
  logic              w_accept, w_done_now, w_commit, w_mem_we;
  logic [DATA_W-1:0] w_addr, w_mem_wdata;
  logic [AW-1:0]     w_idx, w_mem_idx;

  logic [AW-1:0]     r_idx;
  logic [DATA_W-1:0] r_wdata, r_valE;
  logic              r_is_wr, r_is_rd;
  logic [3:0]        r_icode, r_dstE, r_dstM;

  always_comb begin
    w_is_wr = (M_icode == IRMMOVQ) || (M_icode == IPUSHQ) || (M_icode == ICALL);
    w_is_rd = (M_icode == IMRMOVQ) || (M_icode == IPOPQ) || (M_icode == IRET);
    w_addr  = ((M_icode == IPOPQ) || (M_icode == IRET)) ? M_valA : M_valE;
    w_idx   = w_addr[AW+2:3];
`ifdef DMEM_ALIGN_CHECK_EN
    w_fault = ((w_addr >> 3) >= DATA_W'(DEPTH)) || (w_addr[2:0] != 3'd0);
`else
    w_fault = (w_addr >> 3) >= DATA_W'(DEPTH);
`endif
    w_access = (M_stat == SAOK) && (w_is_wr || w_is_rd) && !w_fault;
  end

  // m_stall is derived from state and M_* only, never from m_* outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    m_stall     = 1'b0;
    w_accept    = 1'b0;
    w_done_now  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (M_valid) begin
          if (w_access && (LATENCY > 1)) begin
            w_accept    = 1'b1;
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = CW'(LATENCY - 2);
            m_stall     = 1'b1;
          end else begin
            w_done_now = 1'b1;
          end
        end
      end
      S_BUSY: begin
        m_stall = (r_cnt != '0);
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_we    = !rst && ((w_done_now && w_access && w_is_wr) || (w_commit && r_is_wr));
    w_mem_idx   = w_commit ? r_idx : w_idx;
    w_mem_wdata = w_commit ? r_wdata : M_valA;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_valE  <= '0;
      r_is_wr <= 1'b0;
      r_is_rd <= 1'b0;
      r_icode <= INOP;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_wdata <= M_valA;
        r_valE  <= M_valE;
        r_is_wr <= w_is_wr;
        r_is_rd <= w_is_rd;
        r_icode <= M_icode;
        r_dstE  <= M_dstE;
        r_dstM  <= M_dstM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_stat  <= SAOK;
      m_icode <= INOP;
      m_valE  <= '0;
      m_valM  <= '0;
      m_dstE  <= RNONE;
      m_dstM  <= RNONE;
    end else if (w_done_now) begin
      m_valid <= 1'b1;
      if (M_stat != SAOK)                  m_stat <= M_stat;
      else if ((w_is_wr || w_is_rd) && w_fault) m_stat <= SADR;
      else                                 m_stat <= SAOK;
      m_icode <= M_icode;
      m_valE  <= M_valE;
      m_valM  <= (w_access && w_is_rd) ? r_mem[w_idx] : '0;
      m_dstE  <= M_dstE;
      m_dstM  <= M_dstM;
    end else if (w_commit) begin
      m_valid <= 1'b1;
      m_stat  <= SAOK;
      m_icode <= r_icode;
      m_valE  <= r_valE;
      m_valM  <= r_is_rd ? r_mem[r_idx] : '0;
      m_dstE  <= r_dstE;
      m_dstM  <= r_dstM;
    end else begin
      m_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_stage.sv
`default_nettype none
// tb_dmem_stage - directed scenarios plus randomized instruction stream checked
// against a transaction-level memory model.
module tb_dmem_stage;

  localparam int LAT   = 2;
  localparam int DEPTH = 8192;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } out_t;

  localparam out_t RST_REC = '{valid: 1'b0, stat: 3'd1, icode: 4'd1, valE: 64'd0,
                               valM: 64'd0, dstE: 4'd15, dstM: 4'd15};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M_valid = 1'b0;
  logic [2:0]  M_stat = 3'd1;
  logic [3:0]  M_icode = 4'd1;
  logic [63:0] M_valE = '0, M_valA = '0;
  logic [3:0]  M_dstE = 4'hF, M_dstM = 4'hF;
  logic        m_valid, m_stall;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode, m_dstE, m_dstM;
  logic [63:0] m_valE, m_valM;

  dmem_stage #(.DATA_W(64), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .M_valid(M_valid), .M_stat(M_stat), .M_icode(M_icode),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_valid(m_valid), .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE),
    .m_valM(m_valM), .m_dstE(m_dstE), .m_dstM(m_dstM), .m_stall(m_stall)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   stall_seen;
  out_t exp_res [int];
  bit   exp_stall [int];
  logic [63:0] mem_model [longint];
  out_t cur = RST_REC;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare of every output against the scheduled expectation.
  always @(negedge clk) begin
    out_t act;
    bit   es;
    if (exp_res.exists(cyc)) cur = exp_res[cyc];
    else cur.valid = 1'b0;
    es  = exp_stall.exists(cyc) ? 1'b1 : 1'b0;
    act = '{valid: m_valid, stat: m_stat, icode: m_icode, valE: m_valE,
            valM: m_valM, dstE: m_dstE, dstM: m_dstM};
    n_vec++;
    if (act !== cur || m_stall !== es) begin
      n_err++;
      $display("FAIL cycle%0d outputs: got v=%0b st=%0d ic=%0d vE=%h vM=%h dE=%0d dM=%0d stall=%0b, want v=%0b st=%0d ic=%0d vE=%h vM=%h dE=%0d dM=%0d stall=%0b",
               cyc, act.valid, act.stat, act.icode, act.valE, act.valM, act.dstE, act.dstM, m_stall,
               cur.valid, cur.stat, cur.icode, cur.valE, cur.valM, cur.dstE, cur.dstM, es);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, expv);
    end
  endtask

  function automatic in_t mk(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] vE,
                             input logic [63:0] vA, input logic [3:0] dE, input logic [3:0] dM);
    in_t x;
    x = '{stat: st, icode: ic, valE: vE, valA: vA, dstE: dE, dstM: dM};
    return x;
  endfunction

  // Instruction-level reference: result fields, latency, and memory side effect.
  function automatic void predict(input in_t x, output out_t r, output int lat);
    bit wr, rd, fault;
    logic [63:0] a;
    longint w;
    wr = (x.icode == 4) || (x.icode == 8) || (x.icode == 10);
    rd = (x.icode == 5) || (x.icode == 9) || (x.icode == 11);
    a  = (x.icode == 9 || x.icode == 11) ? x.valA : x.valE;
    fault = (a / 8) >= 64'(DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (a % 8 != 0) fault = 1'b1;
`endif
    w = longint'(a / 8);
    r = '{valid: 1'b1, stat: x.stat, icode: x.icode, valE: x.valE, valM: 64'd0,
          dstE: x.dstE, dstM: x.dstM};
    lat = 1;
    if (x.stat == 3'd1 && (wr || rd)) begin
      if (fault) r.stat = 3'd2;
      else begin
        lat = LAT;
        if (wr) mem_model[w] = x.valA;
        else r.valM = mem_model.exists(w) ? mem_model[w] : 64'd0;
      end
    end
  endfunction

  // Present one instruction, hold it for its full latency; returns in the result cycle.
  task automatic issue(input in_t x);
    out_t r;
    int   lat, k;
    predict(x, r, lat);
    k = cyc;
    exp_res[k + lat] = r;
    for (int i = 0; i < lat - 1; i++) exp_stall[k + i] = 1'b1;
    M_valid = 1'b1; M_stat = x.stat; M_icode = x.icode; M_valE = x.valE;
    M_valA = x.valA; M_dstE = x.dstE; M_dstM = x.dstM;
    stall_seen = 0;
    for (int i = 0; i < lat; i++) begin
      #1;
      if (m_stall) stall_seen++;
      @(posedge clk); #1;
    end
    M_valid = 1'b0;
  endtask

  task automatic bubble();
    M_valid = 1'b0;
    M_icode = 4'($urandom_range(0, 15));
    M_valE  = {$urandom, $urandom};
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    case ($urandom_range(0, 9))
      0:       a = 64'hFFF8;
      1:       a = 64'h10000;
      2:       a = {$urandom, $urandom};
      3:       a = 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(1, 7));
      default: a = 64'($urandom_range(0, 15)) * 8;
    endcase
    return a;
  endfunction

  initial begin
    in_t x;
    int  k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset m_valid", 64'(m_valid), 64'd0);
    check("reset m_stat",  64'(m_stat),  64'd1);
    check("reset m_icode", 64'(m_icode), 64'd1);
    check("reset m_dstE",  64'(m_dstE),  64'd15);
    check("reset m_stall", 64'(m_stall), 64'd0);

    // Reset during BUSY of a write aborts it.
    k = cyc;
    exp_stall[k] = 1'b1;
    M_valid = 1'b1; M_stat = 3'd1; M_icode = 4'h4; M_valE = 64'h200; M_valA = 64'h1234;
    M_dstE = 4'hF; M_dstM = 4'hF;
    @(posedge clk); #1;
    exp_res[k + 1] = RST_REC;
    rst = 1'b1; M_valid = 1'b0;
    #1;
    check("midrst m_valid", 64'(m_valid), 64'd0);
    check("midrst m_stall", 64'(m_stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(mk(3'd1, 4'h5, 64'h200, 64'd0, 4'hF, 4'h3));
    check("aborted write reads 0", m_valM, 64'd0);

    issue(mk(3'd1, 4'h4, 64'h40, 64'hDEADBEEF, 4'hF, 4'hF));
    check("rmmovq stall cycles", 64'(stall_seen), 64'd1);
    issue(mk(3'd1, 4'h5, 64'h40, 64'd0, 4'hF, 4'h2));
    check("mrmovq stall cycles", 64'(stall_seen), 64'd1);
    check("mrmovq m_valM", m_valM, 64'hDEADBEEF);
    check("mrmovq m_stat", 64'(m_stat), 64'd1);

    issue(mk(3'd1, 4'hA, 64'h100, 64'd7, 4'h4, 4'hF));
    issue(mk(3'd1, 4'hB, 64'h108, 64'h100, 4'h4, 4'h5));
    check("popq m_valM", m_valM, 64'd7);
    check("popq m_dstE", 64'(m_dstE), 64'd4);

    issue(mk(3'd1, 4'h5, 64'h10000, 64'd0, 4'hF, 4'h1));
    check("oor m_stat", 64'(m_stat), 64'd2);
    check("oor m_valM", m_valM, 64'd0);
    check("oor stall", 64'(stall_seen), 64'd0);

    issue(mk(3'd1, 4'h6, 64'd5, 64'd0, 4'h2, 4'hF));
    check("opq m_valE", m_valE, 64'd5);
    check("opq stall", 64'(stall_seen), 64'd0);
    issue(mk(3'd4, 4'h0, 64'd0, 64'd0, 4'hF, 4'hF));
    check("halt m_stat", 64'(m_stat), 64'd4);

    issue(mk(3'd1, 4'h4, 64'h43, 64'hAA, 4'hF, 4'hF));
`ifdef DMEM_ALIGN_CHECK_EN
    check("misaligned m_stat", 64'(m_stat), 64'd2);
`else
    check("misaligned m_stat", 64'(m_stat), 64'd1);
    issue(mk(3'd1, 4'h5, 64'h40, 64'd0, 4'hF, 4'h1));
    check("misaligned wrote word 8", m_valM, 64'hAA);
`endif

    for (int n = 0; n < 400; n++) begin
      logic [3:0] ic;
      logic [2:0] st;
      logic [63:0] a;
      if ($urandom_range(0, 4) == 0) begin
        bubble();
        continue;
      end
      case ($urandom_range(0, 7))
        0: ic = 4'h4; 1: ic = 4'h5; 2: ic = 4'hA; 3: ic = 4'hB;
        4: ic = 4'h8; 5: ic = 4'h9;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      st = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      a  = rand_addr();
      if (ic == 4'h9 || ic == 4'hB) x = mk(st, ic, {$urandom, $urandom}, a, 4'($urandom), 4'($urandom));
      else                          x = mk(st, ic, a, {$urandom, $urandom}, 4'($urandom), 4'($urandom));
      issue(x);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
